// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AW_DEF         = 8;
  localparam int unsigned DW_DEF         = 16;
  localparam int unsigned STARVE_MAX_DEF = 3;
  // Wide enough for any STARVE_MAX in 1..15
  localparam int unsigned CNT_W          = 4;

  // Run sequencer states
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } arb_state_e;

  // Owner of the read issued in the previous cycle
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_LD   = 2'd1,
    TAG_D    = 2'd2,
    TAG_I    = 2'd3
  } owner_tag_e;

  // Saturating increment for the fetch starvation counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational grant selection: loader > data > fetch, with a starvation
// override that lets a long-refused fetch jump ahead of a data access.
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             ld_req,
  input  logic             d_req,
  input  logic             i_req,
  input  logic             cpu_en,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             ld_sel_c,
  output logic             d_sel_c,
  output logic             i_sel_c
);

  logic starve_hit;

  assign starve_hit = i_req & (starve_cnt == CNT_W'(STARVE_MAX));

  // One-hot grant; CPU ports are only eligible while the CPU is running
  always_comb begin
    ld_sel_c = 1'b0;
    d_sel_c  = 1'b0;
    i_sel_c  = 1'b0;
    if (ld_req) begin
      ld_sel_c = 1'b1;
    end else if (cpu_en) begin
      if (starve_hit) begin
        i_sel_c = 1'b1;
      end else if (d_req) begin
        d_sel_c = 1'b1;
      end else if (i_req) begin
        i_sel_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter and run sequencer for the 16-bit pipeline CPU.
// Grants are decided within the cycle; read data returns one cycle later
// to whichever requester issued the read.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_done,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          cpu_halt,
  output logic          cpu_hold,
  output logic          cpu_start,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e       state_q;
  owner_tag_e       tag_q;
  logic [CNT_W-1:0] starve_q;
  logic             cpu_en;
  logic [DW-1:0]    ld_rdata_q;
  logic [DW-1:0]    d_rdata_q;
  logic [DW-1:0]    i_rdata_q;

  assign cpu_en = (state_q == ST_RUN);

  mem_arb_priority #(
    .STARVE_MAX (STARVE_MAX)
  ) u_priority (
    .ld_req     (ld_req),
    .d_req      (d_req),
    .i_req      (i_req),
    .cpu_en     (cpu_en),
    .starve_cnt (starve_q),
    .ld_sel_c   (ld_gnt),
    .d_sel_c    (d_gnt),
    .i_sel_c    (i_gnt)
  );

  // Steer the granted requester onto the SRAM port; idle bus is all zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr;
    end
  end

  // Pipeline stall whenever a CPU port waits; meaningless while frozen
  assign stall = ~cpu_hold & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

  // Read data is routed straight from the SRAM in the cycle after the grant
  assign ld_rvalid = (tag_q == TAG_LD);
  assign d_rvalid  = (tag_q == TAG_D);
  assign i_rvalid  = (tag_q == TAG_I);
  assign ld_rdata  = ld_rvalid ? mem_rdata : ld_rdata_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;
  assign i_rdata   = i_rvalid  ? mem_rdata : i_rdata_q;

  // Run sequencer: load -> start pulse -> run -> halted -> start ...
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      cpu_hold  <= 1'b1;
      cpu_start <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      case (state_q)
        ST_LOAD, ST_HALTED: begin
          if (ld_done) begin
            state_q   <= ST_START;
            cpu_hold  <= 1'b0;
            cpu_start <= 1'b1;
          end
        end
        ST_START: begin
          state_q  <= ST_RUN;
          cpu_hold <= 1'b0;
        end
        ST_RUN: begin
          if (cpu_halt) begin
            state_q  <= ST_HALTED;
            cpu_hold <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_LOAD;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  // Count consecutive refused fetches while running
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (i_gnt || !i_req) begin
      starve_q <= '0;
    end else if (cpu_en) begin
      starve_q <= sat_inc(starve_q, CNT_W'(STARVE_MAX));
    end
  end

  // Remember who owns the read issued this cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q <= TAG_NONE;
    end else if (mem_en && !mem_we) begin
      if (ld_gnt) begin
        tag_q <= TAG_LD;
      end else if (d_gnt) begin
        tag_q <= TAG_D;
      end else begin
        tag_q <= TAG_I;
      end
    end else begin
      tag_q <= TAG_NONE;
    end
  end

  // Hold each port's last delivered word between reads
  always_ff @(posedge clock) begin
    if (reset) begin
      ld_rdata_q <= '0;
      d_rdata_q  <= '0;
      i_rdata_q  <= '0;
    end else begin
      if (ld_rvalid) ld_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
      if (i_rvalid)  i_rdata_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: hand-derived vector table for the directed scenarios,
// then randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int SM = 3;
  localparam int P_LOAD = 0, P_START = 1, P_RUN = 2, P_HALT = 3;

  logic        clock;
  logic        reset;
  logic        ld_req, ld_we, ld_done, ld_gnt, ld_rvalid;
  logic [7:0]  ld_addr;
  logic [15:0] ld_wdata, ld_rdata;
  logic        i_req, i_gnt, i_rvalid;
  logic [7:0]  i_addr;
  logic [15:0] i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic        cpu_halt, cpu_hold, cpu_start, stall;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(8), .DW(16), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .cpu_halt(cpu_halt), .cpu_hold(cpu_hold), .cpu_start(cpu_start), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous 256x16 SRAM macro
  logic [15:0] sram [256];
  initial begin
    for (int a = 0; a < 256; a++) sram[a] = 16'h0;
    mem_rdata = 16'h0;
  end
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int who; logic [15:0] data; } rd_t;
  int          m_phase, m_starve;
  rd_t         m_q[$];
  logic [15:0] m_last [3];
  logic [15:0] ref_mem [256];
  int          e_win, e_dv;
  logic [15:0] e_dd, e_wdata;
  logic [7:0]  e_addr;
  logic        e_we, e_hold, e_stall;
  logic [10:0] e_ctrl;
  logic [15:0] e_rd [3];

  task automatic model_reset();
    m_phase = P_LOAD; m_starve = 0; m_q.delete();
    for (int p = 0; p < 3; p++) m_last[p] = 16'h0;
  endtask

  task automatic model_eval();
    e_hold = (m_phase == P_LOAD) || (m_phase == P_HALT);
    e_win = -1;
    if (ld_req) e_win = 0;
    else if (m_phase == P_RUN) begin
      if (i_req && m_starve == SM) e_win = 2;
      else if (d_req)              e_win = 1;
      else if (i_req)              e_win = 2;
    end
    e_we = 1'b0; e_addr = 8'h0; e_wdata = 16'h0;
    if (e_win == 0) begin e_we = ld_we; e_addr = ld_addr; e_wdata = ld_wdata; end
    if (e_win == 1) begin e_we = d_we;  e_addr = d_addr;  e_wdata = d_wdata;  end
    if (e_win == 2) begin e_addr = i_addr; end
    e_stall = !e_hold && ((i_req && e_win != 2) || (d_req && e_win != 1));
    e_dv = -1; e_dd = 16'h0;
    if (m_q.size() > 0) begin e_dv = m_q[0].who; e_dd = m_q[0].data; end
    for (int p = 0; p < 3; p++) e_rd[p] = (e_dv == p) ? e_dd : m_last[p];
    e_ctrl = {e_win == 0, e_win == 1, e_win == 2, e_dv == 0, e_dv == 1, e_dv == 2,
              e_stall, e_hold, m_phase == P_START, e_win >= 0, e_we};
  endtask

  task automatic model_commit();
    if (e_dv >= 0) m_last[e_dv] = e_dd;
    m_q.delete();
    if (e_win >= 0 && e_we) ref_mem[e_addr] = e_wdata;
    if (reset) begin
      model_reset();
    end else begin
      if (e_win >= 0 && !e_we) m_q.push_back('{e_win, ref_mem[e_addr]});
      if (m_phase == P_RUN && i_req && e_win != 2)
        m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
      else if (e_win == 2 || !i_req)
        m_starve = 0;
      case (m_phase)
        P_LOAD, P_HALT: if (ld_done) m_phase = P_START;
        P_START:        m_phase = P_RUN;
        default:        if (cpu_halt) m_phase = P_HALT;
      endcase
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, ld_req, ld_we; logic [7:0] ld_addr; logic [15:0] ld_wdata; logic ld_done;
    logic i_req; logic [7:0] i_addr;
    logic d_req, d_we; logic [7:0] d_addr; logic [15:0] d_wdata; logic halt;
    logic [2:0] x_gnt, x_rv; logic [15:0] x_rdata; logic x_stall, x_hold, x_start, x_we;
  } vec_t;

  function automatic vec_t v(int rst, int lr, int lw, int la, int lwd, int ldn,
                             int ir, int ia, int dr, int dw, int da, int dwd, int h,
                             int g, int rv, int rd, int st, int hd, int sp, int we);
    vec_t r;
    r.rst = 1'(rst); r.ld_req = 1'(lr); r.ld_we = 1'(lw); r.ld_addr = 8'(la);
    r.ld_wdata = 16'(lwd); r.ld_done = 1'(ldn); r.i_req = 1'(ir); r.i_addr = 8'(ia);
    r.d_req = 1'(dr); r.d_we = 1'(dw); r.d_addr = 8'(da); r.d_wdata = 16'(dwd);
    r.halt = 1'(h); r.x_gnt = 3'(g); r.x_rv = 3'(rv); r.x_rdata = 16'(rd);
    r.x_stall = 1'(st); r.x_hold = 1'(hd); r.x_start = 1'(sp); r.x_we = 1'(we);
    return r;
  endfunction

  task automatic apply_vec(input vec_t r);
    reset = r.rst; ld_req = r.ld_req; ld_we = r.ld_we; ld_addr = r.ld_addr;
    ld_wdata = r.ld_wdata; ld_done = r.ld_done; i_req = r.i_req; i_addr = r.i_addr;
    d_req = r.d_req; d_we = r.d_we; d_addr = r.d_addr; d_wdata = r.d_wdata;
    cpu_halt = r.halt;
  endtask

  task automatic check_vec(input int k, input vec_t r);
    logic [15:0] got;
    chk("vec_ctrl", k,
        64'({ld_gnt, d_gnt, i_gnt, ld_rvalid, d_rvalid, i_rvalid,
             stall, cpu_hold, cpu_start, mem_en, mem_we}),
        64'({r.x_gnt, r.x_rv, r.x_stall, r.x_hold, r.x_start, |r.x_gnt, r.x_we}));
    if (r.x_rv != 3'b000) begin
      got = r.x_rv[2] ? ld_rdata : (r.x_rv[1] ? d_rdata : i_rdata);
      chk("vec_rdata", k, 64'(got), 64'(r.x_rdata));
    end
  endtask

  vec_t tbl[$];
  logic p_ld, p_d, p_i;

  initial begin
    //                 rst ld:r w a  wd     dn  i:r a  d:r w a wd    h   gnt    rv     rdata  st hd sp we
    tbl.push_back(v(1, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b000,0,      0,1,0,0)); // reset state
    tbl.push_back(v(0, 1,1,0,'h4412, 0, 0,0, 0,0,0,0,      0, 'b100,'b000,0,      0,1,0,1)); // load word 0
    tbl.push_back(v(0, 1,1,1,'h0800, 0, 0,0, 0,0,0,0,      0, 'b100,'b000,0,      0,1,0,1)); // load word 1
    tbl.push_back(v(0, 0,0,0,0,      1, 0,0, 0,0,0,0,      0, 'b000,'b000,0,      0,1,0,0)); // ld_done
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b000,0,      0,0,1,0)); // START
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 0,0,0,0,      0, 'b001,'b000,0,      0,0,0,0)); // fetch 0
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b001,'h4412, 0,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b010,'b000,0,      1,0,0,0)); // contention
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b010,'b010,'h0800, 1,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b010,'b010,'h0800, 1,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b001,'b010,'h0800, 1,0,0,0)); // starve override
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b010,'b001,'h4412, 1,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b010,'h0800, 0,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 1,1,3,'h6DF1, 0, 'b010,'b000,0,      0,0,0,1)); // store
    tbl.push_back(v(0, 0,0,0,0,      0, 1,3, 0,0,0,0,      0, 'b001,'b000,0,      0,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b001,'h6DF1, 0,0,0,0));
    tbl.push_back(v(0, 1,0,1,0,      0, 1,0, 1,0,0,0,      0, 'b100,'b000,0,      1,0,0,0)); // debug access
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,0,0,      0, 'b010,'b100,'h0800, 1,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b010,'b010,'h4412, 1,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,1,0,      0, 'b001,'b010,'h0800, 1,0,0,0)); // counted ld cycle
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 1,0,1,0,      0, 'b010,'b001,'h4412, 0,0,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 1,1, 0,0,0,0,      1, 'b001,'b010,'h0800, 0,0,0,0)); // halt + read
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 0,0,0,0,      0, 'b000,'b001,'h0800, 0,1,0,0)); // HALTED
    tbl.push_back(v(0, 1,0,3,0,      0, 0,0, 0,0,0,0,      0, 'b100,'b000,0,      0,1,0,0));
    tbl.push_back(v(1, 1,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b100,'b100,'h6DF1, 0,1,0,0)); // reset w/ read
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b000,0,      0,1,0,0)); // discarded
    tbl.push_back(v(0, 0,0,0,0,      0, 1,0, 1,0,0,0,      1, 'b000,'b000,0,      0,1,0,0)); // LOAD, halt ignored
    tbl.push_back(v(0, 0,0,0,0,      1, 0,0, 0,0,0,0,      0, 'b000,'b000,0,      0,1,0,0));
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 1,0,0,0,      0, 'b000,'b000,0,      1,0,1,0)); // START refuses CPU
    tbl.push_back(v(0, 0,0,0,0,      1, 0,0, 1,0,0,0,      0, 'b010,'b000,0,      0,0,0,0)); // ld_done ignored
    tbl.push_back(v(0, 0,0,0,0,      0, 0,0, 0,0,0,0,      0, 'b000,'b010,'h4412, 0,0,0,0));

    for (int a = 0; a < 256; a++) ref_mem[a] = 16'h0;
    apply_vec(v(1, 0,0,0,0, 0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0));
    @(posedge clock); #1;
    model_reset();

    for (int k = 0; k < tbl.size(); k++) begin
      apply_vec(tbl[k]);
      @(negedge clock);
      check_vec(k, tbl[k]);
      model_eval();
      model_commit();
      @(posedge clock); #1;
    end

    // Randomized traffic; requesters hold their request until granted
    p_ld = 1'b0; p_d = 1'b0; p_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!p_ld && $urandom_range(0, 6) == 0) begin
        p_ld = 1'b1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = 8'($urandom_range(0, 15)); ld_wdata = 16'($urandom);
      end
      if (!p_d && $urandom_range(0, 4) < 2) begin
        p_d = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
      end
      if (!p_i && $urandom_range(0, 1) == 0) begin
        p_i = 1'b1; i_addr = 8'($urandom_range(0, 15));
      end
      ld_req = p_ld; d_req = p_d; i_req = p_i;
      ld_done  = ($urandom_range(0, 19) == 0);
      cpu_halt = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clock);
      model_eval();
      chk("rnd_ctrl", c,
          64'({ld_gnt, d_gnt, i_gnt, ld_rvalid, d_rvalid, i_rvalid,
               stall, cpu_hold, cpu_start, mem_en, mem_we}), 64'(e_ctrl));
      if (e_win >= 0)
        chk("rnd_bus", c, 64'({mem_addr, mem_we ? mem_wdata : 16'h0}),
            64'({e_addr, e_we ? e_wdata : 16'h0}));
      chk("rnd_rdata", c, 64'({ld_rdata, d_rdata, i_rdata}),
          64'({e_rd[0], e_rd[1], e_rd[2]}));
      if (e_win == 0) p_ld = 1'b0;
      if (e_win == 1) p_d  = 1'b0;
      if (e_win == 2) p_i  = 1'b0;
      model_commit();
      @(posedge clock); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
